// File: rtl/dpi_seq_pkg.sv
// rtl/dpi_seq_pkg.sv - shared constants and FSM state type for the DPI stream sequencer
package dpi_seq_pkg;

    localparam int NUM_STREAMS = 64;
    localparam int STREAM_ID_W = 6;
    localparam int KEY_W       = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_LOAD,
        S_WAIT,
        S_STREAM,
        S_DRAIN,
        S_EOP,
        S_REPORT
    } seq_state_t;

endpackage

// File: rtl/dpi_stream_table.sv
// rtl/dpi_stream_table.sv - flow key table: parallel compare, round-robin allocation and eviction
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (clears valid bits and alloc pointer)
//   lookup      : high for the single lookup cycle; a miss writes key at alloc_ptr
//   key         : flow key to look up
//   id          : matching index on a hit, alloc_ptr on a miss (combinational)
//   is_new      : 1 when the key missed and a slot is being (re)allocated
module dpi_stream_table
    import dpi_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   lookup,
    input  logic [KEY_W-1:0]       key,
    output logic [STREAM_ID_W-1:0] id,
    output logic                   is_new
);

    logic [KEY_W-1:0]       keys [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] valid;
    logic [STREAM_ID_W-1:0] alloc_ptr;
    logic [STREAM_ID_W-1:0] hit_idx;
    logic                   hit;

    // Keys are unique in the table, so at most one entry can match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (!hit && valid[i] && keys[i] == key) begin
                hit     = 1'b1;
                hit_idx = STREAM_ID_W'(i);
            end
        end
    end

    assign id     = hit ? hit_idx : alloc_ptr;
    assign is_new = ~hit;

    // A miss always overwrites the slot at alloc_ptr, which evicts the
    // oldest allocation once all 64 slots are in use.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid     <= '0;
            alloc_ptr <= '0;
        end else if (lookup && !hit) begin
            valid[alloc_ptr] <= 1'b1;
            alloc_ptr        <= alloc_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (lookup && !hit) begin
            keys[alloc_ptr] <= key;
        end
    end

endmodule

// File: rtl/dpi_stream_sequencer.sv
// rtl/dpi_stream_sequencer.sv - packet-to-matcher sequencer with flow table and result reporting
//
// Optional feature macro: DPI_SEQ_ENABLE_MASK_EN (per-stream enable mask and cfg_* writes).
//
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   in_valid/in_ready/in_data       : byte stream in; in_sop/in_eop frame it, in_key tags the flow at sop
//   char_in/char_in_vld/load_state  : registered matcher drive
//   stream_id/new_stream_id/eop     : registered matcher drive, stream context
//   enable                          : registered per-stream enable at eop (constant 1 without the mask)
//   fired_vec                       : concatenated matcher fired flags, sampled while eop is high
//   res_valid/res_ready             : result handshake, res_stream_id/res_fired payload
//   cfg_we/cfg_addr/cfg_en          : mask write port
module dpi_stream_sequencer
    import dpi_seq_pkg::*;
#(
    parameter int NUM_REGEX = 16,
    parameter int LOAD_GAP  = 2,
    parameter int DRAIN_GAP = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic [KEY_W-1:0]       in_key,
    output logic [7:0]             char_in,
    output logic                   char_in_vld,
    output logic                   load_state,
    output logic [STREAM_ID_W-1:0] stream_id,
    output logic                   new_stream_id,
    output logic                   eop,
    output logic                   enable,
    input  logic [NUM_REGEX-1:0]   fired_vec,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [STREAM_ID_W-1:0] res_stream_id,
    output logic [NUM_REGEX-1:0]   res_fired,
    input  logic                   cfg_we,
    input  logic [STREAM_ID_W-1:0] cfg_addr,
    input  logic                   cfg_en
);

    localparam logic [7:0] LOAD_LAST  = 8'(LOAD_GAP - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_GAP - 1);

    seq_state_t             state;
    seq_state_t             next;
    logic [7:0]             cnt;
    logic [KEY_W-1:0]       key_q;
    logic [STREAM_ID_W-1:0] tbl_id;
    logic                   tbl_new;

    dpi_stream_table u_table (
        .clk    (clk),
        .rst_n  (rst_n),
        .lookup (state == S_LOOKUP),
        .key    (key_q),
        .id     (tbl_id),
        .is_new (tbl_new)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next;
        end
    end

    // in_ready is combinational so a non-sop byte in IDLE is dropped in the
    // same cycle it is offered; a sop byte is held for STREAM to consume.
    always_comb begin
        next     = state;
        in_ready = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = in_valid && !in_sop;
                if (in_valid && in_sop) next = S_LOOKUP;
            end
            S_LOOKUP: next = S_LOAD;
            S_LOAD:   next = (LOAD_GAP == 0) ? S_STREAM : S_WAIT;
            S_WAIT:   if (cnt == LOAD_LAST) next = S_STREAM;
            S_STREAM: begin
                in_ready = 1'b1;
                if (in_valid && in_eop) next = (DRAIN_GAP == 0) ? S_EOP : S_DRAIN;
            end
            S_DRAIN:  if (cnt == DRAIN_LAST) next = S_EOP;
            S_EOP:    next = S_REPORT;
            S_REPORT: if (res_valid && res_ready) next = S_IDLE;
            default:  next = S_IDLE;
        endcase
        if (!rst_n) in_ready = 1'b0;
    end

    // load_state and eop trail their states by one cycle, so WAIT/DRAIN
    // spans line up with the idle gaps the matchers see on their ports.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt           <= '0;
            key_q         <= '0;
            char_in       <= '0;
            char_in_vld   <= 1'b0;
            load_state    <= 1'b0;
            stream_id     <= '0;
            new_stream_id <= 1'b0;
            eop           <= 1'b0;
            res_valid     <= 1'b0;
            res_stream_id <= '0;
            res_fired     <= '0;
        end else begin
            cnt <= (next != state) ? 8'd0 : cnt + 8'd1;
            if (state == S_IDLE && in_valid && in_sop) key_q <= in_key;
            if (state == S_LOOKUP) begin
                stream_id     <= tbl_id;
                new_stream_id <= tbl_new;
            end
            load_state  <= (state == S_LOAD);
            char_in_vld <= (state == S_STREAM) && in_valid;
            if (state == S_STREAM && in_valid) char_in <= in_data;
            eop <= (state == S_EOP);
            if (eop) begin
                res_valid     <= 1'b1;
                res_stream_id <= stream_id;
                res_fired     <= fired_vec;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef DPI_SEQ_ENABLE_MASK_EN
    logic [NUM_STREAMS-1:0] mask;

    // enable samples mask before a same-cycle cfg write lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask   <= '1;
            enable <= 1'b0;
        end else begin
            if (cfg_we) mask[cfg_addr] <= cfg_en;
            enable <= (state == S_EOP) && mask[stream_id];
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = &{1'b0, cfg_we, cfg_addr, cfg_en};
    assign enable     = 1'b1;
`endif

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// tb/tb_dpi_stream_sequencer.sv - directed self-checking bench for dpi_stream_sequencer
module tb_dpi_stream_sequencer;

    localparam int NR        = 16;
    localparam int LOAD_GAP  = 2;
    localparam int DRAIN_GAP = 3;
`ifdef DPI_SEQ_ENABLE_MASK_EN
    localparam logic EN_MASKED_EXP = 1'b0;
    localparam logic EN_RESET_EXP  = 1'b0;
`else
    localparam logic EN_MASKED_EXP = 1'b1;
    localparam logic EN_RESET_EXP  = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = '0;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic [15:0]   in_key = '0;
    logic [7:0]    char_in;
    logic          char_in_vld;
    logic          load_state;
    logic [5:0]    stream_id;
    logic          new_stream_id;
    logic          eop;
    logic          enable;
    logic [NR-1:0] fired_vec = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [5:0]    res_stream_id;
    logic [NR-1:0] res_fired;
    logic          cfg_we = 1'b0;
    logic [5:0]    cfg_addr = '0;
    logic          cfg_en = 1'b0;

    int compared = 0;
    int mismatched = 0;

    dpi_stream_sequencer #(
        .NUM_REGEX (NR),
        .LOAD_GAP  (LOAD_GAP),
        .DRAIN_GAP (DRAIN_GAP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_sop        (in_sop),
        .in_eop        (in_eop),
        .in_key        (in_key),
        .char_in       (char_in),
        .char_in_vld   (char_in_vld),
        .load_state    (load_state),
        .stream_id     (stream_id),
        .new_stream_id (new_stream_id),
        .eop           (eop),
        .enable        (enable),
        .fired_vec     (fired_vec),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_stream_id (res_stream_id),
        .res_fired     (res_fired),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_en        (cfg_en)
    );

    always #5 clk = ~clk;

    // Event recorder sampled on the falling edge; tasks read deltas of these.
    int         cyc = 0;
    int         load_total = 0;
    int         load_cyc = 0;
    int         eop_total = 0;
    int         eop_cyc = 0;
    int         res_rise = 0;
    logic [5:0] ld_sid = '0;
    logic       ld_new = 1'b0;
    logic       eop_en = 1'b0;
    logic       res_prev = 1'b0;
    logic [7:0] chars[$];
    int         char_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (load_state) begin
            load_total++;
            load_cyc = cyc;
            ld_sid   = stream_id;
            ld_new   = new_stream_id;
        end
        if (char_in_vld) begin
            chars.push_back(char_in);
            char_cyc.push_back(cyc);
        end
        if (eop) begin
            eop_total++;
            eop_cyc = cyc;
            eop_en  = enable;
        end
        if (res_valid && !res_prev) res_rise++;
        res_prev = res_valid;
    end

    task automatic send_packet(input logic [15:0] key, input int n, input logic [7:0] base, input string name);
        int   i = 0;
        int   guard = 0;
        logic acc;
        in_valid = 1'b1;
        in_sop   = 1'b1;
        in_key   = key;
        in_data  = base;
        in_eop   = (n == 1);
        while (i < n && guard < 300) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                i++;
                in_sop  = 1'b0;
                in_data = base + 8'(i);
                in_eop  = (i == n - 1);
                if (i == n) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        compared++;
        if (i != n) begin
            mismatched++;
            $display("FAIL %s accepted: got %0d bytes want %0d", name, i, n);
        end
    endtask

    task automatic wait_result(input string name, output logic [5:0] sid, output logic [NR-1:0] fired);
        int guard = 0;
        while (!res_valid && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        compared++;
        if (res_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL %s res_valid: got %b want 1 within 100 cycles", name, res_valid);
        end
        sid   = res_stream_id;
        fired = res_fired;
    endtask

    task automatic ack_result();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic run_packet(input logic [15:0] key, input int n, input logic [7:0] base, input string name,
                              output logic [5:0] sid, output logic [NR-1:0] fired);
        send_packet(key, n, base, name);
        wait_result(name, sid, fired);
        ack_result();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_sop   = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        compared++;
        if ({in_ready, char_in, char_in_vld, load_state, stream_id, new_stream_id, eop} !== '0) begin
            mismatched++;
            $display("FAIL reset_drive: got rdy=%b ch=%h vld=%b ld=%b sid=%0d new=%b eop=%b want all 0",
                     in_ready, char_in, char_in_vld, load_state, stream_id, new_stream_id, eop);
        end
        compared++;
        if ({res_valid, res_stream_id, res_fired} !== '0) begin
            mismatched++;
            $display("FAIL reset_result: got valid=%b sid=%0d fired=%h want 0", res_valid, res_stream_id, res_fired);
        end
        compared++;
        if (enable !== EN_RESET_EXP) begin
            mismatched++;
            $display("FAIL reset_enable: got %b want %b", enable, EN_RESET_EXP);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_idle_discard();
        int l0 = load_total;
        int c0 = chars.size();
        in_valid = 1'b1;
        in_sop   = 1'b0;
        in_data  = 8'h77;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL idle_discard_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        compared++;
        if (load_total != l0 || chars.size() != c0) begin
            mismatched++;
            $display("FAIL idle_discard_quiet: got loads=%0d chars=%0d want 0 0", load_total - l0, chars.size() - c0);
        end
    endtask

    task automatic test_first_packet();
        logic [5:0]    sid;
        logic [NR-1:0] fired;
        int l0 = load_total;
        int c0 = chars.size();
        int e0 = eop_total;
        run_packet(16'h1234, 4, 8'hA0, "first", sid, fired);
        compared++;
        if (ld_new !== 1'b1 || ld_sid !== 6'd0) begin
            mismatched++;
            $display("FAIL first_lookup: got new=%b sid=%0d want new=1 sid=0", ld_new, ld_sid);
        end
        compared++;
        if (load_total - l0 != 1) begin
            mismatched++;
            $display("FAIL first_load_count: got %0d want 1", load_total - l0);
        end
        compared++;
        if (chars.size() - c0 != 4) begin
            mismatched++;
            $display("FAIL first_char_count: got %0d want 4", chars.size() - c0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                compared++;
                if (chars[c0 + k] !== 8'hA0 + 8'(k)) begin
                    mismatched++;
                    $display("FAIL first_char%0d: got %h want %h", k, chars[c0 + k], 8'hA0 + 8'(k));
                end
            end
            compared++;
            if (char_cyc[c0] - load_cyc != LOAD_GAP + 1) begin
                mismatched++;
                $display("FAIL first_load_gap: got %0d want %0d", char_cyc[c0] - load_cyc, LOAD_GAP + 1);
            end
            compared++;
            if (eop_cyc - char_cyc[c0 + 3] != DRAIN_GAP + 1) begin
                mismatched++;
                $display("FAIL first_drain_gap: got %0d want %0d", eop_cyc - char_cyc[c0 + 3], DRAIN_GAP + 1);
            end
        end
        compared++;
        if (eop_total - e0 != 1 || eop_en !== 1'b1) begin
            mismatched++;
            $display("FAIL first_eop: got count=%0d en=%b want 1 1", eop_total - e0, eop_en);
        end
        compared++;
        if (sid !== 6'd0) begin
            mismatched++;
            $display("FAIL first_res_sid: got %0d want 0", sid);
        end
    endtask

    task automatic test_hit_and_new();
        logic [5:0]    sid;
        logic [NR-1:0] fired;
        run_packet(16'h1234, 2, 8'h10, "hit", sid, fired);
        compared++;
        if (ld_new !== 1'b0 || ld_sid !== 6'd0 || sid !== 6'd0) begin
            mismatched++;
            $display("FAIL hit_1234: got new=%b sid=%0d res=%0d want 0 0 0", ld_new, ld_sid, sid);
        end
        run_packet(16'hBEEF, 3, 8'h20, "new", sid, fired);
        compared++;
        if (ld_new !== 1'b1 || ld_sid !== 6'd1 || sid !== 6'd1) begin
            mismatched++;
            $display("FAIL new_beef: got new=%b sid=%0d res=%0d want 1 1 1", ld_new, ld_sid, sid);
        end
    endtask

    task automatic test_mask();
        logic [5:0]    sid;
        logic [NR-1:0] fired;
        cfg_we   = 1'b1;
        cfg_addr = 6'd0;
        cfg_en   = 1'b0;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        run_packet(16'h1234, 2, 8'h30, "mask", sid, fired);
        compared++;
        if (ld_sid !== 6'd0 || eop_en !== EN_MASKED_EXP) begin
            mismatched++;
            $display("FAIL mask_enable: got sid=%0d en=%b want sid=0 en=%b", ld_sid, eop_en, EN_MASKED_EXP);
        end
    endtask

    task automatic test_single_byte_backpressure();
        logic [5:0]    sid;
        logic [NR-1:0] fired;
        logic          stable = 1'b1;
        logic          rdy_seen = 1'b0;
        int c0 = chars.size();
        fired_vec = 16'h0005;
        send_packet(16'h0042, 1, 8'h3C, "single");
        wait_result("single", sid, fired);
        fired_vec = 16'h00F0;
        compared++;
        if (fired !== 16'h0005 || sid !== 6'd2 || ld_new !== 1'b1) begin
            mismatched++;
            $display("FAIL single_result: got fired=%h sid=%0d new=%b want 0005 2 1", fired, sid, ld_new);
        end
        compared++;
        if (chars.size() - c0 != 1 || chars[c0] !== 8'h3C) begin
            mismatched++;
            $display("FAIL single_char: got n=%0d ch=%h want 1 3c", chars.size() - c0, chars[c0]);
        end
        in_valid = 1'b1;
        in_sop   = 1'b0;
        in_data  = 8'h99;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (in_ready) rdy_seen = 1'b1;
            if (res_valid !== 1'b1 || res_fired !== 16'h0005 || res_stream_id !== 6'd2) stable = 1'b0;
        end
        compared++;
        if (rdy_seen !== 1'b0) begin
            mismatched++;
            $display("FAIL hold_in_ready: got %b want 0", rdy_seen);
        end
        compared++;
        if (stable !== 1'b1) begin
            mismatched++;
            $display("FAIL hold_result_stable: got %b want 1", stable);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        ack_result();
    endtask

    task automatic test_eviction();
        logic [5:0]    sid;
        logic [NR-1:0] fired;
        apply_reset();
        for (int i = 0; i < 65; i++) begin
            run_packet(16'h1000 + 16'(i), 1, 8'(i), "evict", sid, fired);
            compared++;
            if (ld_new !== 1'b1 || ld_sid !== 6'(i)) begin
                mismatched++;
                $display("FAIL evict_key%0d: got new=%b sid=%0d want 1 %0d", i, ld_new, ld_sid, i % 64);
            end
        end
        run_packet(16'h1000, 1, 8'h00, "evicted", sid, fired);
        compared++;
        if (ld_new !== 1'b1 || ld_sid !== 6'd1) begin
            mismatched++;
            $display("FAIL evicted_relookup: got new=%b sid=%0d want 1 1", ld_new, ld_sid);
        end
        run_packet(16'h1002, 1, 8'h00, "survivor", sid, fired);
        compared++;
        if (ld_new !== 1'b0 || ld_sid !== 6'd2) begin
            mismatched++;
            $display("FAIL survivor_hit: got new=%b sid=%0d want 0 2", ld_new, ld_sid);
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [5:0]    sid;
        logic [NR-1:0] fired;
        int guard = 0;
        int c0 = chars.size();
        int e0 = eop_total;
        int r0 = res_rise;
        in_valid = 1'b1;
        in_sop   = 1'b1;
        in_key   = 16'h1002;
        in_data  = 8'h55;
        in_eop   = 1'b0;
        while (chars.size() - c0 < 2 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
            in_sop = 1'b0;
        end
        compared++;
        if (chars.size() - c0 < 2) begin
            mismatched++;
            $display("FAIL midrst_streaming: got %0d chars want >=2", chars.size() - c0);
        end
        in_valid = 1'b0;
        apply_reset();
        repeat (20) begin @(posedge clk); #1; end
        compared++;
        if (eop_total != e0 || res_rise != r0) begin
            mismatched++;
            $display("FAIL midrst_abandon: got eops=%0d results=%0d want 0 0", eop_total - e0, res_rise - r0);
        end
        run_packet(16'h1002, 2, 8'h60, "after_rst", sid, fired);
        compared++;
        if (ld_new !== 1'b1 || ld_sid !== 6'd0 || sid !== 6'd0) begin
            mismatched++;
            $display("FAIL midrst_relookup: got new=%b sid=%0d res=%0d want 1 0 0", ld_new, ld_sid, sid);
        end
    endtask

    initial begin
        test_reset();
        test_idle_discard();
        test_first_packet();
        test_hit_and_new();
        test_mask();
        test_single_byte_backpressure();
        test_eviction();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
